// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the ADC frame receiver.
package adc_rx_pkg;

   localparam int N_CH = 128;
   localparam int DW   = 8;
   localparam int AW   = 7;
   localparam int FCW  = 16;

   // Index is one bit wider than AW so it can hold N_CH itself.
   localparam logic [AW:0] N_CH_IDX = (AW+1)'(N_CH);

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      IDLE    = 2'd1,
      CAPTURE = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/adc_frame_ram.sv
// Ping-pong frame store: 2 banks x N_CH samples, one write port and one registered read port.
module adc_frame_ram
   import adc_rx_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          wbank,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          rbank,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2*N_CH];

   always_ff @(posedge clk) begin
      if (we) mem[{wbank, waddr}] <= wdata;
   end

   // Read stage: one cycle from raddr to rdata.
   always_ff @(posedge clk) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[{rbank, raddr}];
   end

endmodule

// File: rtl/adc_frame_receiver.sv
// Frame capture FSM, bank pointer and status counters for the ADC readout stream.
// Optional ramp pattern checker enabled by defining RAMP_CHECK_EN.
module adc_frame_receiver
   import adc_rx_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic [DW-1:0]  adc_data,
   input  logic           adc_update,
   output logic           frame_valid,
   input  logic           frame_ack,
   input  logic [AW-1:0]  rd_addr,
   output logic [DW-1:0]  rd_data,
   output logic [FCW-1:0] frame_cnt,
   output logic [7:0]     len_err_cnt,
   output logic [7:0]     ovr_cnt
`ifdef RAMP_CHECK_EN
   ,
   output logic           ramp_err
`endif
);

   state_t        state;
   logic          wbank;
   logic [AW:0]   index;
   logic          valid_after_ack;
   logic          swap;
   logic          we;
   logic          wsel;
   logic [AW-1:0] waddr;

   // A same-cycle ack frees the read bank before COMMIT decides whether to swap.
   always_comb begin
      valid_after_ack = frame_valid & ~frame_ack;
      swap            = (state == COMMIT) && !valid_after_ack;
      wsel            = swap ? ~wbank : wbank;
      we              = 1'b0;
      waddr           = '0;
      unique case (state)
         IDLE, COMMIT: we = adc_update;
         CAPTURE: begin
            we    = adc_update && (index < N_CH_IDX);
            waddr = index[AW-1:0];
         end
         default: we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SYNC;
         wbank       <= 1'b0;
         index       <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         len_err_cnt <= '0;
         ovr_cnt     <= '0;
      end else begin
         if (frame_ack) frame_valid <= 1'b0;
         unique case (state)
            SYNC: begin
               if (!adc_update) state <= IDLE;
            end
            IDLE: begin
               if (adc_update) begin
                  index <= (AW+1)'(1);
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (adc_update) begin
                  if (index < N_CH_IDX) begin
                     index <= index + (AW+1)'(1);
                  end else begin
                     len_err_cnt <= sat8(len_err_cnt);
                     state       <= SYNC;
                  end
               end else if (index == N_CH_IDX) begin
                  state <= COMMIT;
               end else begin
                  len_err_cnt <= sat8(len_err_cnt);
                  state       <= IDLE;
               end
            end
            COMMIT: begin
               if (swap) begin
                  wbank       <= ~wbank;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + FCW'(1);
               end else begin
                  ovr_cnt <= sat8(ovr_cnt);
               end
               if (adc_update) begin
                  index <= (AW+1)'(1);
                  state <= CAPTURE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

`ifdef RAMP_CHECK_EN
   logic ramp_bad;
   logic mismatch;

   assign mismatch = (adc_data != DW'(waddr));

   // ramp_bad accumulates over the frame; sample 0 restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ramp_bad <= 1'b0;
         ramp_err <= 1'b0;
      end else begin
         if (we) ramp_bad <= ((state == CAPTURE) ? ramp_bad : 1'b0) | mismatch;
         if (state == COMMIT && ramp_bad) ramp_err <= 1'b1;
      end
   end
`endif

   adc_frame_ram u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .wbank (wsel),
      .waddr (waddr),
      .wdata (adc_data),
      .rbank (~wbank),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_adc_frame_receiver.sv
// Directed bench for adc_frame_receiver with a read-data scoreboard.
module tb_adc_frame_receiver;
   import adc_rx_pkg::*;

   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  adc_data;
   logic           adc_update;
   logic           frame_valid;
   logic           frame_ack;
   logic [AW-1:0]  rd_addr;
   logic [DW-1:0]  rd_data;
   logic [FCW-1:0] frame_cnt;
   logic [7:0]     len_err_cnt;
   logic [7:0]     ovr_cnt;
`ifdef RAMP_CHECK_EN
   logic           ramp_err;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_bank [N_CH];
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   adc_frame_receiver dut (
      .clk         (clk),
      .reset       (reset),
      .adc_data    (adc_data),
      .adc_update  (adc_update),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_cnt   (frame_cnt),
      .len_err_cnt (len_err_cnt),
      .ovr_cnt     (ovr_cnt)
`ifdef RAMP_CHECK_EN
      ,
      .ramp_err    (ramp_err)
`endif
   );

   function automatic logic [7:0] pat_val(input int pat, input int i);
      logic [7:0] b;
      b = 8'(i);
      case (pat)
         1:       return b ^ 8'hA5;
         2:       return 8'(i * 3);
         3:       return ~b;
         4:       return b + 8'd7;
         5:       return (i == 77) ? 8'hFF : b;
         default: return b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; adc_update = 1'b0; frame_ack = 1'b0; adc_data = '0; rd_addr = '0;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
   endtask

   // Drives n samples with update high; pulses frame_ack on sample ack_at (-1 = never).
   task automatic send_burst(input int n, input int pat, input int ack_at);
      for (int i = 0; i < n; i++) begin
         adc_update = 1'b1;
         adc_data   = pat_val(pat, i);
         frame_ack  = (i == ack_at);
         tick();
      end
      adc_update = 1'b0;
      frame_ack  = 1'b0;
   endtask

   task automatic set_exp(input int pat);
      for (int i = 0; i < N_CH; i++) exp_bank[i] = pat_val(pat, i);
   endtask

   task automatic read_all(input string tag);
      logic [7:0] e;
      for (int a = 0; a < N_CH; a++) begin
         rd_addr = AW'(a);
         exp_q.push_back(exp_bank[a]);
         tick();
         e = exp_q.pop_front();
         check(tag, 32'(rd_data), 32'(e));
      end
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      reset = 1'b1; adc_update = 1'b0; frame_ack = 1'b0; adc_data = '0; rd_addr = '0;
      tick(); tick();
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_len", 32'(len_err_cnt), 32'd0);
      check("rst_ovr", 32'(ovr_cnt), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);
      reset = 1'b0;
      tick(); tick();

      // T1: one good ramp frame
      send_burst(N_CH, 0, -1);
      tick();
      check("t1_valid_early", 32'(frame_valid), 32'd0);
      tick();
      check("t1_valid", 32'(frame_valid), 32'd1);
      check("t1_fcnt", 32'(frame_cnt), 32'd1);
      rd_addr = AW'(5);
      tick();
      check("t1_rd5", 32'(rd_data), 32'd5);
      set_exp(0);
      read_all("t1_rd");
      pulse_ack();
      check("t1_ack_clear", 32'(frame_valid), 32'd0);
      pulse_ack();
      check("t1_ack_ignored", 32'(frame_valid), 32'd0);

      // T2: short then long burst
      send_burst(100, 1, -1);
      tick(); tick();
      check("t2_len1", 32'(len_err_cnt), 32'd1);
      check("t2_valid", 32'(frame_valid), 32'd0);
      send_burst(N_CH + 1, 1, -1);
      check("t2_len2", 32'(len_err_cnt), 32'd2);
      tick(); tick(); tick();
      check("t2_no_commit_valid", 32'(frame_valid), 32'd0);
      check("t2_no_commit_fcnt", 32'(frame_cnt), 32'd1);
      // frame after the discard still captures normally
      send_burst(N_CH, 2, -1);
      tick(); tick();
      check("t2_recover_fcnt", 32'(frame_cnt), 32'd2);
      set_exp(2);
      read_all("t2_rd");

      // T3: two good frames without ack
      do_reset();
      send_burst(N_CH, 0, -1);
      tick(); tick();
      send_burst(N_CH, 1, -1);
      tick(); tick();
      check("t3_valid", 32'(frame_valid), 32'd1);
      check("t3_ovr", 32'(ovr_cnt), 32'd1);
      check("t3_fcnt", 32'(frame_cnt), 32'd1);
      set_exp(0);
      read_all("t3_rd");

      // T4: ack coincident with COMMIT of frame 2
      do_reset();
      send_burst(N_CH, 0, -1);
      tick(); tick();
      send_burst(N_CH, 1, -1);
      tick();
      pulse_ack();
      check("t4_valid", 32'(frame_valid), 32'd1);
      check("t4_fcnt", 32'(frame_cnt), 32'd2);
      check("t4_ovr", 32'(ovr_cnt), 32'd0);
      set_exp(1);
      read_all("t4_rd");

      // Back-to-back frames: next frame starts in the COMMIT cycle
      pulse_ack();
      send_burst(N_CH, 2, -1);
      tick();
      send_burst(N_CH, 3, 10);
      tick(); tick();
      check("b2b_fcnt", 32'(frame_cnt), 32'd4);
      check("b2b_ovr", 32'(ovr_cnt), 32'd0);
      check("b2b_valid", 32'(frame_valid), 32'd1);
      set_exp(3);
      read_all("b2b_rd");

      // T5: reset released mid-burst, also clears a pending frame
      reset = 1'b1; adc_update = 1'b1; adc_data = 8'h33;
      tick(); tick();
      check("t5_rst_valid", 32'(frame_valid), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         adc_data = 8'(i);
         tick();
      end
      adc_update = 1'b0;
      tick(); tick(); tick();
      check("t5_len", 32'(len_err_cnt), 32'd0);
      check("t5_fcnt0", 32'(frame_cnt), 32'd0);
      check("t5_valid0", 32'(frame_valid), 32'd0);
      send_burst(N_CH, 4, -1);
      tick(); tick();
      check("t5_fcnt1", 32'(frame_cnt), 32'd1);
      check("t5_valid1", 32'(frame_valid), 32'd1);
      set_exp(4);
      read_all("t5_rd");

      // len_err_cnt saturation with one-sample bursts
      for (int i = 0; i < 260; i++) begin
         send_burst(1, 0, -1);
         tick();
      end
      tick();
      check("len_sat", 32'(len_err_cnt), 32'd255);

`ifdef RAMP_CHECK_EN
      // T6: ramp checker
      do_reset();
      check("t6_rst", 32'(ramp_err), 32'd0);
      send_burst(N_CH, 0, -1);
      tick(); tick();
      check("t6_clean", 32'(ramp_err), 32'd0);
      pulse_ack();
      send_burst(N_CH, 5, -1);
      tick();
      check("t6_pre_commit", 32'(ramp_err), 32'd0);
      tick();
      check("t6_set", 32'(ramp_err), 32'd1);
      pulse_ack();
      send_burst(N_CH, 0, -1);
      tick(); tick();
      check("t6_sticky", 32'(ramp_err), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
